// File: rtl/ysyx_2022040010_axi_bridge_pkg.sv
// Shared definitions for the data-side AXI bridge.
// Contents: FSM state encoding, fixed AXI size/response codes, the reset
// polarity (`RstEnable / RST_ENABLE) and a response-decoding helper.
`ifndef RstEnable
`define RstEnable 1'b1
`endif

package ysyx_2022040010_axi_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [2:0] AXI_SIZE_8B = 3'b011;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic       RST_ENABLE  = `RstEnable;

  // Any response other than OKAY is reported to the requester as an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != RESP_OKAY);
  endfunction

endpackage

// File: rtl/ysyx_2022040010_axi_bridge_if.sv
// Single-beat AXI4-style bus between the bridge (master) and the SoC (slave).
// Channels: AR (ar_valid/ar_ready/ar_addr/ar_size), R (r_valid/r_ready/
// r_data/r_resp), AW (aw_valid/aw_ready/aw_addr/aw_size), W (w_valid/w_ready/
// w_data/w_strb), B (b_valid/b_ready/b_resp).
interface ysyx_2022040010_axi_bridge_if #(
  parameter int AXI_ADDR_W = 32
);
  import ysyx_2022040010_axi_bridge_pkg::*;

  logic                  ar_valid;
  logic                  ar_ready;
  logic [AXI_ADDR_W-1:0] ar_addr;
  logic [2:0]            ar_size;
  logic                  r_valid;
  logic                  r_ready;
  logic [63:0]           r_data;
  logic [1:0]            r_resp;
  logic                  aw_valid;
  logic                  aw_ready;
  logic [AXI_ADDR_W-1:0] aw_addr;
  logic [2:0]            aw_size;
  logic                  w_valid;
  logic                  w_ready;
  logic [63:0]           w_data;
  logic [7:0]            w_strb;
  logic                  b_valid;
  logic                  b_ready;
  logic [1:0]            b_resp;

  modport master (
    output ar_valid, ar_addr, ar_size, input ar_ready,
    input  r_valid, r_data, r_resp, output r_ready,
    output aw_valid, aw_addr, aw_size, input aw_ready,
    output w_valid, w_data, w_strb, input w_ready,
    input  b_valid, b_resp, output b_ready
  );

  modport slave (
    input  ar_valid, ar_addr, ar_size, output ar_ready,
    output r_valid, r_data, r_resp, input r_ready,
    input  aw_valid, aw_addr, aw_size, output aw_ready,
    input  w_valid, w_data, w_strb, output w_ready,
    output b_valid, b_resp, input b_ready
  );

endinterface

// File: rtl/ysyx_2022040010_axi_watchdog.sv
// Transaction watchdog for the AXI bridge.
// Ports: clk, rst (sync, active-high), busy (bridge is waiting on the bus),
// expire (high in the busy cycle where TIMEOUT_CYCLES-1 is reached).
module ysyx_2022040010_axi_watchdog
  import ysyx_2022040010_axi_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  output logic expire
);

  localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_r;

  // Busy-cycle counter; held at zero whenever the bridge is not waiting.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      cnt_r <= {CW{1'b0}};
    end else if (!busy) begin
      cnt_r <= {CW{1'b0}};
    end else if (cnt_r != LIMIT) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = busy && (cnt_r == LIMIT);

endmodule

// File: rtl/ysyx_2022040010_axi_bridge.sv
// Responder for the LSU data-side request port: turns one req_e request into
// a single-beat AXI read (AR/R) or write (AW/W/B) and answers with a one-cycle
// refresh pulse, read data and an error flag.
// Ports: clk, rst (sync, active-high), req_e/req_we/req_addr/req_wdata/
// req_wsel (request), refresh/rdata/resp_err (completion), axi (bus master).
// Optional: define AXI_BRIDGE_TIMEOUT_EN to abort a stuck transaction after
// TIMEOUT_CYCLES busy cycles with resp_err=1.
module ysyx_2022040010_axi_bridge
  import ysyx_2022040010_axi_bridge_pkg::*;
#(
  parameter int AXI_ADDR_W     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_e,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wsel,
  output logic        refresh,
  output logic [63:0] rdata,
  output logic        resp_err,
  ysyx_2022040010_axi_bridge_if.master axi
);

  state_t                state_r, state_nxt;
  logic                  guard_r, guard_nxt;
  logic [AXI_ADDR_W-1:0] addr_r, addr_nxt;
  logic [63:0]           wdata_r, wdata_nxt;
  logic [7:0]            wsel_r, wsel_nxt;
  logic                  ar_valid_r, ar_valid_nxt;
  logic                  r_ready_r, r_ready_nxt;
  logic                  aw_valid_r, aw_valid_nxt;
  logic                  w_valid_r, w_valid_nxt;
  logic                  b_ready_r, b_ready_nxt;
  logic                  aw_done_r, aw_done_nxt;
  logic                  w_done_r, w_done_nxt;
  logic [63:0]           rdata_r, rdata_nxt;
  logic                  resp_err_r, resp_err_nxt;
  logic                  refresh_r;
  logic                  aw_done_s, w_done_s;
  logic                  busy_s, expire_s;

  assign busy_s = (state_r == RD_ADDR) || (state_r == RD_DATA) ||
                  (state_r == WR_REQ)  || (state_r == WR_RESP);

`ifdef AXI_BRIDGE_TIMEOUT_EN
  ysyx_2022040010_axi_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .busy   (busy_s),
    .expire (expire_s)
  );
`else
  logic unused_timeout_s;
  assign expire_s         = 1'b0;
  assign unused_timeout_s = busy_s & (TIMEOUT_CYCLES > 0);
`endif

  // Only the low AXI_ADDR_W address bits reach the bus.
  if (AXI_ADDR_W < 64) begin : g_addr_drop
    logic unused_addr_s;
    assign unused_addr_s = ^req_addr[63:AXI_ADDR_W];
  end

  // AW and W finish independently; a handshake this cycle counts as done.
  assign aw_done_s = aw_done_r | (aw_valid_r & axi.aw_ready);
  assign w_done_s  = w_done_r  | (w_valid_r  & axi.w_ready);

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_nxt    = state_r;
    guard_nxt    = guard_r;
    addr_nxt     = addr_r;
    wdata_nxt    = wdata_r;
    wsel_nxt     = wsel_r;
    ar_valid_nxt = ar_valid_r;
    r_ready_nxt  = r_ready_r;
    aw_valid_nxt = aw_valid_r;
    w_valid_nxt  = w_valid_r;
    b_ready_nxt  = b_ready_r;
    aw_done_nxt  = aw_done_r;
    w_done_nxt   = w_done_r;
    rdata_nxt    = rdata_r;
    resp_err_nxt = resp_err_r;
    case (state_r)
      IDLE: begin
        // The guard swallows the request still asserted right after DONE.
        guard_nxt = 1'b0;
        if (req_e && !guard_r) begin
          addr_nxt  = req_addr[AXI_ADDR_W-1:0];
          wdata_nxt = req_wdata;
          wsel_nxt  = req_wsel;
          if (req_we) begin
            aw_valid_nxt = 1'b1;
            w_valid_nxt  = 1'b1;
            aw_done_nxt  = 1'b0;
            w_done_nxt   = 1'b0;
            state_nxt    = WR_REQ;
          end else begin
            ar_valid_nxt = 1'b1;
            state_nxt    = RD_ADDR;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      RD_ADDR: begin
        if (ar_valid_r && axi.ar_ready) begin
          ar_valid_nxt = 1'b0;
          r_ready_nxt  = 1'b1;
          state_nxt    = RD_DATA;
        end else begin
          state_nxt = RD_ADDR;
        end
      end
      RD_DATA: begin
        if (axi.r_valid && r_ready_r) begin
          rdata_nxt    = axi.r_data;
          resp_err_nxt = resp_is_err(axi.r_resp);
          r_ready_nxt  = 1'b0;
          state_nxt    = DONE;
        end else begin
          state_nxt = RD_DATA;
        end
      end
      WR_REQ: begin
        aw_valid_nxt = aw_valid_r & ~axi.aw_ready;
        w_valid_nxt  = w_valid_r & ~axi.w_ready;
        aw_done_nxt  = aw_done_s;
        w_done_nxt   = w_done_s;
        if (aw_done_s && w_done_s) begin
          b_ready_nxt = 1'b1;
          state_nxt   = WR_RESP;
        end else begin
          state_nxt = WR_REQ;
        end
      end
      WR_RESP: begin
        if (axi.b_valid && b_ready_r) begin
          resp_err_nxt = resp_is_err(axi.b_resp);
          b_ready_nxt  = 1'b0;
          state_nxt    = DONE;
        end else begin
          state_nxt = WR_RESP;
        end
      end
      DONE: begin
        guard_nxt = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        ar_valid_nxt = 1'b0;
        r_ready_nxt  = 1'b0;
        aw_valid_nxt = 1'b0;
        w_valid_nxt  = 1'b0;
        b_ready_nxt  = 1'b0;
        state_nxt    = IDLE;
      end
    endcase
    // A watchdog abort overrides whatever the handshakes decided this cycle.
    if (expire_s) begin
      ar_valid_nxt = 1'b0;
      r_ready_nxt  = 1'b0;
      aw_valid_nxt = 1'b0;
      w_valid_nxt  = 1'b0;
      b_ready_nxt  = 1'b0;
      resp_err_nxt = 1'b1;
      state_nxt    = DONE;
    end else begin
      guard_nxt = guard_nxt;
    end
  end

  // State and output registers; refresh is high for the single DONE cycle.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_r    <= IDLE;
      guard_r    <= 1'b0;
      addr_r     <= {AXI_ADDR_W{1'b0}};
      wdata_r    <= 64'd0;
      wsel_r     <= 8'd0;
      ar_valid_r <= 1'b0;
      r_ready_r  <= 1'b0;
      aw_valid_r <= 1'b0;
      w_valid_r  <= 1'b0;
      b_ready_r  <= 1'b0;
      aw_done_r  <= 1'b0;
      w_done_r   <= 1'b0;
      rdata_r    <= 64'd0;
      resp_err_r <= 1'b0;
      refresh_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      guard_r    <= guard_nxt;
      addr_r     <= addr_nxt;
      wdata_r    <= wdata_nxt;
      wsel_r     <= wsel_nxt;
      ar_valid_r <= ar_valid_nxt;
      r_ready_r  <= r_ready_nxt;
      aw_valid_r <= aw_valid_nxt;
      w_valid_r  <= w_valid_nxt;
      b_ready_r  <= b_ready_nxt;
      aw_done_r  <= aw_done_nxt;
      w_done_r   <= w_done_nxt;
      rdata_r    <= rdata_nxt;
      resp_err_r <= resp_err_nxt;
      refresh_r  <= (state_nxt == DONE);
    end
  end

  assign refresh      = refresh_r;
  assign rdata        = rdata_r;
  assign resp_err     = resp_err_r;
  assign axi.ar_valid = ar_valid_r;
  assign axi.ar_addr  = addr_r;
  assign axi.ar_size  = AXI_SIZE_8B;
  assign axi.r_ready  = r_ready_r;
  assign axi.aw_valid = aw_valid_r;
  assign axi.aw_addr  = addr_r;
  assign axi.aw_size  = AXI_SIZE_8B;
  assign axi.w_valid  = w_valid_r;
  assign axi.w_data   = wdata_r;
  assign axi.w_strb   = wsel_r;
  assign axi.b_ready  = b_ready_r;

endmodule

// File: tb/tb_ysyx_2022040010_axi_bridge.sv
// Self-checking bench for ysyx_2022040010_axi_bridge: a configurable AXI slave,
// a transaction-level model of rdata/resp_err/refresh, a per-cycle compare
// process and directed scenarios with hand-computed expectations.
module tb_ysyx_2022040010_axi_bridge;

  logic        clk;
  logic        rst, req_e, req_we;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wsel;
  logic        refresh, resp_err;
  logic [63:0] rdata;

  ysyx_2022040010_axi_bridge_if #(.AXI_ADDR_W(32)) axi ();

  ysyx_2022040010_axi_bridge #(.AXI_ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req_e(req_e), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wsel(req_wsel), .refresh(refresh),
    .rdata(rdata), .resp_err(resp_err), .axi(axi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Slave configuration (set by the scenarios)
  int          ar_delay = 0, aw_delay = 0, w_delay = 0, r_delay = 0;
  logic [63:0] rd_cfg = 64'd0;
  logic [1:0]  rresp_cfg = 2'b00, bresp_cfg = 2'b00;

  // Transaction model state
  logic        outstanding = 1'b0, txn_we = 1'b0, exp_timeout = 1'b0;
  logic [63:0] txn_addr = 64'd0, txn_wdata = 64'd0;
  logic [7:0]  txn_wsel = 8'd0;
  logic [63:0] model_rdata = 64'd0;
  logic        model_err = 1'b0;
  int ar_hs_txn = 0, aw_hs_txn = 0, w_hs_txn = 0, r_hs_txn = 0, b_hs_txn = 0, b_rise_txn = 0;
  int ar_hs_total = 0, cyc = 0, last_aw_cyc = 0, last_w_cyc = 0;
  logic [31:0] last_ar_addr = 32'd0;
  logic [63:0] last_w_data = 64'd0;
  logic [7:0]  last_w_strb = 8'd0;
  logic        ref_ar_valid = 1'b0;

  // AXI slave: readies/valids updated 2 time units after each rising edge
  initial begin
    int ar_c, aw_c, w_c, r_c;
    ar_c = 0; aw_c = 0; w_c = 0; r_c = 0;
    axi.ar_ready = 1'b0; axi.aw_ready = 1'b0; axi.w_ready = 1'b0;
    axi.r_valid = 1'b0; axi.r_data = 64'd0; axi.r_resp = 2'b00;
    axi.b_valid = 1'b0; axi.b_resp = 2'b00;
    forever begin
      @(posedge clk); #2;
      if (axi.ar_valid) begin axi.ar_ready = (ar_c >= ar_delay); ar_c++; end
      else begin axi.ar_ready = 1'b0; ar_c = 0; end
      if (axi.aw_valid) begin axi.aw_ready = (aw_c >= aw_delay); aw_c++; end
      else begin axi.aw_ready = 1'b0; aw_c = 0; end
      if (axi.w_valid) begin axi.w_ready = (w_c >= w_delay); w_c++; end
      else begin axi.w_ready = 1'b0; w_c = 0; end
      if (axi.r_ready) begin axi.r_valid = (r_c >= r_delay); r_c++; end
      else begin axi.r_valid = 1'b0; r_c = 0; end
      axi.r_data  = rd_cfg;
      axi.r_resp  = rresp_cfg;
      axi.b_valid = axi.b_ready;
      axi.b_resp  = bresp_cfg;
    end
  end

  // Compare process: checks protocol rules and the model on every cycle
  initial begin
    logic prev_rst, pv_ar, pr_ar, pv_aw, pr_aw, pv_w, pr_w, pv_b, prev_ref;
    prev_rst = 1'b1; pv_ar = 1'b0; pr_ar = 1'b0; pv_aw = 1'b0; pr_aw = 1'b0;
    pv_w = 1'b0; pr_w = 1'b0; pv_b = 1'b0; prev_ref = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_rst) begin
        model_rdata = 64'd0; model_err = 1'b0; outstanding = 1'b0;
        chk("rst_refresh", refresh, 0);
        chk("rst_ar_valid", axi.ar_valid, 0);
        chk("rst_aw_valid", axi.aw_valid, 0);
        chk("rst_w_valid", axi.w_valid, 0);
        chk("rst_r_ready", axi.r_ready, 0);
        chk("rst_b_ready", axi.b_ready, 0);
      end else begin
        if (pv_ar && !pr_ar) chk("ar_valid_hold", axi.ar_valid, (exp_timeout && refresh) ? 1'b0 : 1'b1);
        if (pv_aw && !pr_aw) chk("aw_valid_hold", axi.aw_valid, (exp_timeout && refresh) ? 1'b0 : 1'b1);
        if (pv_w && !pr_w) chk("w_valid_hold", axi.w_valid, (exp_timeout && refresh) ? 1'b0 : 1'b1);
        if (axi.ar_valid) begin
          chk("ar_owner", outstanding && !txn_we, 1);
          chk("ar_addr", axi.ar_addr, txn_addr[31:0]);
          chk("ar_size", axi.ar_size, 3'b011);
        end
        if (axi.aw_valid) begin
          chk("aw_addr", axi.aw_addr, txn_addr[31:0]);
          chk("aw_size", axi.aw_size, 3'b011);
        end
        if (axi.w_valid) begin
          chk("w_data", axi.w_data, txn_wdata);
          chk("w_strb", axi.w_strb, txn_wsel);
        end
        if (axi.b_ready) begin
          chk("b_after_aw", aw_hs_txn, 1);
          chk("b_after_w", w_hs_txn, 1);
          if (!pv_b) b_rise_txn++;
        end
        if (refresh) begin
          chk("refresh_expected", outstanding, 1);
          chk("refresh_pulse", prev_ref, 0);
          ref_ar_valid = axi.ar_valid;
          if (outstanding) begin
            if (exp_timeout) begin
              model_err = 1'b1;
            end else if (!txn_we) begin
              chk("read_r_done", r_hs_txn, 1);
              model_rdata = rd_cfg;
              model_err = (rresp_cfg != 2'b00);
            end else begin
              chk("write_b_done", b_hs_txn, 1);
              model_err = (bresp_cfg != 2'b00);
            end
            outstanding = 1'b0;
          end
        end
        chk("rdata_model", rdata, model_rdata);
        chk("resp_err_model", resp_err, model_err);
      end
      // Handshakes that will complete on the coming rising edge
      if (axi.ar_valid && axi.ar_ready) begin ar_hs_txn++; ar_hs_total++; last_ar_addr = axi.ar_addr; end
      if (axi.aw_valid && axi.aw_ready) begin aw_hs_txn++; last_aw_cyc = cyc; end
      if (axi.w_valid && axi.w_ready) begin
        w_hs_txn++; last_w_cyc = cyc; last_w_data = axi.w_data; last_w_strb = axi.w_strb;
      end
      if (axi.r_valid && axi.r_ready) r_hs_txn++;
      if (axi.b_valid && axi.b_ready) b_hs_txn++;
      prev_rst = rst; prev_ref = refresh;
      pv_ar = axi.ar_valid; pr_ar = axi.ar_ready;
      pv_aw = axi.aw_valid; pr_aw = axi.aw_ready;
      pv_w = axi.w_valid; pr_w = axi.w_ready; pv_b = axi.b_ready;
    end
  end

  task automatic start_req(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [7:0] wsel);
    @(posedge clk); #1;
    req_e = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wsel = wsel;
    txn_we = we; txn_addr = addr; txn_wdata = wdata; txn_wsel = wsel; outstanding = 1'b1;
    ar_hs_txn = 0; aw_hs_txn = 0; w_hs_txn = 0; r_hs_txn = 0; b_hs_txn = 0; b_rise_txn = 0;
  endtask

  // Issue one request, return cycles until refresh (-1 if none within budget)
  task automatic do_req(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] wsel, input int budget, input int hold_extra,
                        output int lat);
    start_req(we, addr, wdata, wsel);
    lat = -1;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (refresh) begin lat = n; break; end
    end
    for (int k = 0; k < hold_extra; k++) @(posedge clk);
    @(posedge clk); #1;
    req_e = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit actual=expired required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int lat, ar_before;
    logic seen;
    rst = 1'b1; req_e = 1'b0; req_we = 1'b0; req_addr = 64'd0; req_wdata = 64'd0; req_wsel = 8'd0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    chk("reset_rdata", rdata, 64'd0);
    chk("reset_resp_err", resp_err, 0);

    // Read with ar_ready delayed 3 cycles
    ar_delay = 3; rd_cfg = 64'h1122334455667788; rresp_cfg = 2'b00;
    do_req(1'b0, 64'h0000_0000_8000_0010, 64'd0, 8'd0, 40, 0, lat);
    chk("read1_latency", lat, 7);
    chk("read1_ar_addr", last_ar_addr, 32'h8000_0010);
    chk("read1_rdata", rdata, 64'h1122334455667788);
    chk("read1_err", resp_err, 0);
    chk("read1_ar_count", ar_hs_txn, 1);

    // Best-case read
    ar_delay = 0; rd_cfg = 64'hA5A5_0000_FFFF_1234;
    do_req(1'b0, 64'hFFFF_0000_1000_0008, 64'd0, 8'd0, 40, 0, lat);
    chk("read2_latency", lat, 4);
    chk("read2_ar_addr_trunc", last_ar_addr, 32'h1000_0008);
    chk("read2_rdata", rdata, 64'hA5A5_0000_FFFF_1234);

    // Write: W accepted two cycles before AW
    aw_delay = 2; w_delay = 0; bresp_cfg = 2'b00;
    do_req(1'b1, 64'h0000_0000_8000_0100, 64'hDEADBEEF_CAFEF00D, 8'h0F, 40, 0, lat);
    chk("write1_latency", lat, 6);
    chk("write1_w_strb", last_w_strb, 8'h0F);
    chk("write1_w_data", last_w_data, 64'hDEADBEEF_CAFEF00D);
    chk("write1_w_before_aw", last_w_cyc + 2, last_aw_cyc);
    chk("write1_err", resp_err, 0);
    chk("write1_rdata_held", rdata, 64'hA5A5_0000_FFFF_1234);

    // Write: AW and W in the same cycle, SLVERR response
    aw_delay = 0; bresp_cfg = 2'b10;
    do_req(1'b1, 64'h0000_0000_8000_0200, 64'h0123_4567_89AB_CDEF, 8'hF0, 40, 0, lat);
    chk("write2_latency", lat, 4);
    chk("write2_b_ready_rises", b_rise_txn, 1);
    chk("write2_err", resp_err, 1);
    chk("write2_aw_count", aw_hs_txn, 1);

    // req_e held through the refresh cycle and the next cycle: one AR only
    ar_before = ar_hs_total; rd_cfg = 64'h0000_0000_0000_BEEF;
    do_req(1'b0, 64'h0000_0000_8000_0300, 64'd0, 8'd0, 40, 1, lat);
    repeat (5) @(negedge clk);
    chk("guard_latency", lat, 4);
    chk("guard_single_ar", ar_hs_total - ar_before, 1);
    chk("guard_err_cleared", resp_err, 0);

    // Reset while waiting in RD_DATA
    r_delay = 6; rd_cfg = 64'h7777_7777_7777_7777;
    start_req(1'b0, 64'h0000_0000_8000_0400, 64'd0, 8'd0);
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (axi.r_ready) begin seen = 1'b1; break; end
    end
    chk("rst_mid_reached_rd_data", seen, 1);
    @(posedge clk); #1; rst = 1'b1; req_e = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_r_ready", axi.r_ready, 0);
    chk("rst_mid_refresh", refresh, 0);
    chk("rst_mid_rdata", rdata, 64'd0);
    repeat (4) @(negedge clk);
    r_delay = 0; rd_cfg = 64'h0BAD_F00D_0000_0042;
    do_req(1'b0, 64'h0000_0000_8000_0500, 64'd0, 8'd0, 40, 0, lat);
    chk("after_rst_latency", lat, 4);
    chk("after_rst_rdata", rdata, 64'h0BAD_F00D_0000_0042);

    // AR never accepted
    ar_delay = 100000;
`ifdef AXI_BRIDGE_TIMEOUT_EN
    exp_timeout = 1'b1;
    do_req(1'b0, 64'h0000_0000_8000_0600, 64'd0, 8'd0, 40, 0, lat);
    chk("timeout_latency", lat, 18);
    chk("timeout_ar_valid", ref_ar_valid, 0);
    chk("timeout_err", resp_err, 1);
    chk("timeout_rdata_kept", rdata, 64'h0BAD_F00D_0000_0042);
    exp_timeout = 1'b0;
`else
    do_req(1'b0, 64'h0000_0000_8000_0600, 64'd0, 8'd0, 40, 0, lat);
    chk("stall_no_refresh", lat, -1);
    chk("stall_ar_valid", axi.ar_valid, 1);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
`endif
    ar_delay = 0;
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
